regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Shares that port between two requesters:
  - the core writeback path, which is single-cycle, highest priority and never back-pressured;
  - the load/store unit (LSU) response path, which uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard and raises a stall for RAW/WAW hazards against loads still in flight.

Parameters:
- DEPTH, 2, LSU response FIFO entries (power of 2, at least 2).
- STARVE_LIMIT, 4, consecutive blocked cycles before the core is held (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_we  in  1  core writeback valid this cycle.
- core_rd  in  5  core destination register.
- core_wd  in  32  core writeback data.
- lsu_valid  in  1  LSU response valid.
- lsu_ready  out  1  FIFO can accept an LSU response.
- lsu_rd  in  5  LSU destination register.
- lsu_wd  in  32  LSU load data.
- load_issue  in  1  a load is issued this cycle.
- load_rd  in  5  destination register of the issued load.
- rs1  in  5  source 1 of the current instruction.
- rs2  in  5  source 2 of the current instruction.
- hazard_stall  out  1  current instruction must stall.
- core_hold  out  1  core must not write back this cycle (anti-starvation).
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO is empty; pending[31:0]=0; starve counter=0.
  - While rst_n=0, outputs are forced: rf_we=0, lsu_ready=0, hazard_stall=0, core_hold=0, rf_waddr=0, rf_wdata=0.
  - Reset asserted mid-operation discards all buffered responses and scoreboard bits.
- Write-port grant (combinational, same cycle):
  - If core_we=1, core_rd!=0 and core_hold=0: rf_we=1 and rf_waddr/rf_wdata take core_rd/core_wd.
  - Otherwise, if the FIFO is non-empty: the head entry is written and popped at the clock edge.
  - Otherwise rf_we=0.
- x0 handling:
  - A core write with core_rd=0 does not use the port, so the FIFO may drain in that cycle.
  - An LSU response with lsu_rd=0 is accepted but not pushed, and no write occurs.
- Handshake:
  - lsu_ready = !full, independent of a same-cycle pop; no pass-through when full.
  - A push occurs when lsu_valid && lsu_ready.
  - Minimum LSU-to-regfile latency is 1 cycle (no empty bypass).
  - Push and pop in the same cycle are allowed at any occupancy below full. Count is unchanged; pointers wrap modulo DEPTH.
- Scoreboard:
  - load_issue with load_rd!=0 sets pending[load_rd] at the clock edge.
  - A FIFO pop writing register r clears pending[r].
  - If set and clear hit the same register in the same cycle, set wins (a new load is outstanding).
  - pending[0] is always 0.
- Hazard stall:
  - hazard_stall = pending[rs1] | pending[rs2] | (core_we & pending[core_rd]).
  - The stall is combinational, from the current-cycle pending bits.
- Ordering:
  - Responses are written in FIFO order.
  - The core must never write a register with its pending bit set; the WAW stall enforces this.

Optional Feature:
- Macro: REGFILE_ARB_ANTI_STARVE_EN.
- Enabled:
  - The counter increments each cycle the FIFO is non-empty and the core wins the port.
  - The counter resets to 0 when a pop occurs or the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, core_hold=1 for exactly one cycle. That cycle the FIFO head is written and the counter clears.
  - The core must treat core_hold like a stall: its writeback is retried next cycle.
- Disabled:
  - core_hold is tied to 0 and no counter exists.
  - The LSU may starve indefinitely under continuous core writes.

Decomposition:
- Package regfile_arb_pkg:
  - XLEN=32, REG_AW=5, NUM_REGS=32.
  - typedef wb_entry_t {logic [4:0] rd; logic [31:0] wd;}.
- Sub-module wb_fifo:
  - Parameterised by DEPTH, storing wb_entry_t.
  - Ports: push, pop, full, empty, head.
  - Asynchronous active-low reset on pointers and count.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 3 cycles, then release.
  - Required: rf_we=0, lsu_ready=1, hazard_stall=0, pending all 0.
- Load lifecycle:
  - Stimulus: load_issue with load_rd=5 at cycle 0; rs1=5 at cycle 1; LSU response rd=5, wd=0xDEADBEEF at cycle 3 with core idle.
  - Required: hazard_stall=1 at cycle 1. At cycle 4, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. pending[5] clears, so hazard_stall=0 from cycle 5.
- Priority and drain:
  - Stimulus: core_we=1 (rd=3) for 3 cycles while two LSU responses (rd=7, then rd=8) arrive.
  - Required: lsu_ready=0 after 2 pushes. The core writes all 3 cycles. Writes to 7 and then 8 occur in the next 2 idle cycles.
- x0 handling:
  - Stimulus: LSU response with lsu_rd=0; core_we=1 with core_rd=0 while the FIFO holds an entry.
  - Required: the x0 response is accepted with no write. The core x0 write is ignored and the FIFO head is written that cycle.
- Set/clear collision:
  - Stimulus: pop of rd=9 in the same cycle as load_issue with load_rd=9.
  - Required: pending[9] stays 1.
- Anti-starvation (feature enabled):
  - Stimulus: STARVE_LIMIT=4, continuous core_we=1 with rd=2, one LSU entry buffered.
  - Required: core_hold=1 on the 5th blocked cycle and the LSU entry is written that cycle.
  - With the feature disabled, the LSU entry is never written while core writes continue.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
package regfile_arb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback entries; DEPTH must be a power of two (>= 2).
module wb_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    wb_entry_t     mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: core writeback first, buffered LSU responses otherwise,
// plus a pending-load scoreboard. Optional anti-starvation: REGFILE_ARB_ANTI_STARVE_EN.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_we,
    input  logic [REG_AW-1:0] core_rd,
    input  logic [XLEN-1:0]   core_wd,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_wd,
    input  logic              load_issue,
    input  logic [REG_AW-1:0] load_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              hazard_stall,
    output logic              core_hold,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    wb_entry_t           fifo_head;
    wb_entry_t           lsu_entry;
    logic                core_win;
    logic                hold;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    assign lsu_entry = '{rd: lsu_rd, wd: lsu_wd};
    assign lsu_ready = rst_n && !fifo_full;
    // x0 responses complete the handshake but never occupy a slot.
    assign fifo_push = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign core_win  = core_we && (core_rd != '0) && !hold;
    assign fifo_pop  = !core_win && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (lsu_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

`ifdef REGFILE_ARB_ANTI_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (core_win) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign hold = (starve_cnt == SW'(STARVE_LIMIT));
`else
    logic unused_starve_limit;

    assign hold                = 1'b0;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    assign core_hold = rst_n && hold;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (rst_n) begin
            if (core_win) begin
                rf_we    = 1'b1;
                rf_waddr = core_rd;
                rf_wdata = core_wd;
            end else if (fifo_pop) begin
                rf_we    = 1'b1;
                rf_waddr = fifo_head.rd;
                rf_wdata = fifo_head.wd;
            end
        end
    end

    // Set after clear so a newly issued load to the popped register stays pending.
    always_comb begin
        pending_nxt = pending;
        if (fifo_pop) pending_nxt[fifo_head.rd] = 1'b0;
        if (load_issue && (load_rd != '0)) pending_nxt[load_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign hazard_stall = rst_n && (pending[rs1] || pending[rs2] || (core_we && pending[core_rd]));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then random traffic vs a queue model.
module tb_regfile_wb_arbiter;
    import regfile_arb_pkg::*;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_wd;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wd;
    logic        load_issue;
    logic [4:0]  load_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard_stall;
    logic        core_hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_we      (core_we),
        .core_rd      (core_rd),
        .core_wd      (core_wd),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_wd       (lsu_wd),
        .load_issue   (load_issue),
        .load_rd      (load_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .hazard_stall (hazard_stall),
        .core_hold    (core_hold),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of buffered responses, pending flags, starvation age.
    wb_entry_t   q[$];
    logic [31:0] pend;
    int          starve;
    logic        m_hold;
    logic        m_win;
    logic        m_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        core_we    = 1'b0;
        core_rd    = '0;
        core_wd    = '0;
        lsu_valid  = 1'b0;
        lsu_rd     = '0;
        lsu_wd     = '0;
        load_issue = 1'b0;
        load_rd    = '0;
        rs1        = '0;
        rs2        = '0;
    endtask

    // Let the inputs settle and compare every output against the model.
    task automatic settle();
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        #2;
        if (!rst_n) begin
            chk("rst_rf_we", 32'(rf_we), 32'd0);
            chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
            chk("rst_stall", 32'(hazard_stall), 32'd0);
            chk("rst_hold", 32'(core_hold), 32'd0);
            chk("rst_waddr", 32'(rf_waddr), 32'd0);
            chk("rst_wdata", rf_wdata, 32'd0);
            return;
        end
`ifdef REGFILE_ARB_ANTI_STARVE_EN
        m_hold = (starve == STARVE_LIMIT);
`else
        m_hold = 1'b0;
`endif
        m_ready = (q.size() < DEPTH);
        m_win   = core_we && (core_rd != 5'd0) && !m_hold;
        e_we    = m_win || (q.size() > 0);
        e_addr  = m_win ? core_rd : (q.size() > 0 ? q[0].rd : 5'd0);
        e_data  = m_win ? core_wd : (q.size() > 0 ? q[0].wd : 32'd0);
        chk("lsu_ready", 32'(lsu_ready), 32'(m_ready));
        chk("core_hold", 32'(core_hold), 32'(m_hold));
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("stall", 32'(hazard_stall), 32'(pend[rs1] | pend[rs2] | (core_we & pend[core_rd])));
        if (e_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
            chk("rf_wdata", rf_wdata, e_data);
        end
    endtask

    // Advance the model and the DUT by one clock.
    task automatic tick();
        int  pre_size;
        logic popped;
        wb_entry_t e;
        if (!rst_n) begin
            q.delete();
            pend   = '0;
            starve = 0;
        end else begin
            pre_size = q.size();
            popped   = !m_win && (pre_size > 0);
            if (popped) begin
                e = q.pop_front();
                pend[e.rd] = 1'b0;
            end
            if (lsu_valid && m_ready && (lsu_rd != 5'd0))
                q.push_back('{rd: lsu_rd, wd: lsu_wd});
            if (load_issue && (load_rd != 5'd0)) pend[load_rd] = 1'b1;
            if (popped || pre_size == 0) starve = 0;
            else if (m_win)               starve++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    initial begin
        pend   = '0;
        starve = 0;
        m_hold = 1'b0;
        m_win  = 1'b0;
        m_ready = 1'b0;
        drive_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset with active inputs: outputs must stay forced low.
        core_we = 1'b1; core_rd = 5'd3; core_wd = 32'h1234_5678; lsu_valid = 1'b1; lsu_rd = 5'd4;
        for (int i = 0; i < 3; i++) cyc();
        drive_idle();
        rst_n = 1'b1;
        cyc();
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r);
            settle();
            chk("idle_no_pending", 32'(hazard_stall), 32'd0);
            tick();
        end
        drive_idle();

        // Load lifecycle on x5.
        load_issue = 1'b1; load_rd = 5'd5; cyc();
        load_issue = 1'b0; rs1 = 5'd5; settle();
        chk("life_stall_c1", 32'(hazard_stall), 32'd1); tick();
        cyc();
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_wd = 32'hDEAD_BEEF; cyc();
        lsu_valid = 1'b0; settle();
        chk("life_we_c4", 32'(rf_we), 32'd1);
        chk("life_addr_c4", 32'(rf_waddr), 32'd5);
        chk("life_data_c4", rf_wdata, 32'hDEAD_BEEF);
        tick();
        settle();
        chk("life_stall_c5", 32'(hazard_stall), 32'd0); tick();
        drive_idle();

        // Core priority while two responses fill the FIFO, then drain in order.
        core_we = 1'b1; core_rd = 5'd3;
        for (int i = 0; i < 3; i++) begin
            core_wd   = 32'hC000_0000 + 32'(i);
            lsu_valid = (i < 2);
            lsu_rd    = (i == 0) ? 5'd7 : 5'd8;
            lsu_wd    = 32'hA000_0000 + 32'(i);
            settle();
            chk("prio_core_addr", 32'(rf_waddr), 32'd3);
            if (i == 2) chk("prio_ready_full", 32'(lsu_ready), 32'd0);
            tick();
        end
        drive_idle();
        settle(); chk("drain_first", 32'(rf_waddr), 32'd7); tick();
        settle(); chk("drain_second", 32'(rf_waddr), 32'd8); tick();
        settle(); chk("drain_done", 32'(rf_we), 32'd0); tick();

        // x0 handling.
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'h0BAD_0BAD; settle();
        chk("x0_lsu_ready", 32'(lsu_ready), 32'd1); tick();
        lsu_valid = 1'b0; settle();
        chk("x0_lsu_nowrite", 32'(rf_we), 32'd0); tick();
        core_we = 1'b1; core_rd = 5'd4; core_wd = 32'h4444_4444;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wd = 32'h1010_1010; cyc();
        lsu_valid = 1'b0; core_rd = 5'd0; core_wd = 32'hFFFF_FFFF; settle();
        chk("x0_core_drain_addr", 32'(rf_waddr), 32'd10);
        chk("x0_core_drain_data", rf_wdata, 32'h1010_1010);
        tick();
        drive_idle();

        // Scoreboard set/clear collision on x9.
        load_issue = 1'b1; load_rd = 5'd9; cyc();
        load_issue = 1'b0; core_we = 1'b1; core_rd = 5'd1;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'h9999_0000; cyc();
        drive_idle();
        load_issue = 1'b1; load_rd = 5'd9; settle();
        chk("coll_pop_addr", 32'(rf_waddr), 32'd9); tick();
        drive_idle(); rs2 = 5'd9; settle();
        chk("coll_still_pending", 32'(hazard_stall), 32'd1); tick();
        drive_idle();

        // Starvation scenario: one entry buffered under continuous core writes.
        core_we = 1'b1; core_rd = 5'd2;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_wd = 32'hBBBB_0011; cyc();
        lsu_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            core_wd = 32'h2222_0000 + 32'(i);
            settle();
`ifdef REGFILE_ARB_ANTI_STARVE_EN
            if (i == 5) begin
                chk("starve_hold", 32'(core_hold), 32'd1);
                chk("starve_lsu_written", 32'(rf_waddr), 32'd11);
            end
`else
            chk("starve_core_owns", 32'(rf_waddr), 32'd2);
`endif
            tick();
        end
        drive_idle();
        cyc();
        cyc();

        // Random traffic with occasional mid-run resets.
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            core_we    = $urandom_range(0, 1) == 1;
            core_rd    = 5'($urandom_range(0, 7));
            core_wd    = $urandom;
            lsu_valid  = $urandom_range(0, 2) != 0;
            lsu_rd     = 5'($urandom_range(0, 7));
            lsu_wd     = $urandom;
            load_issue = $urandom_range(0, 2) == 0;
            load_rd    = 5'($urandom_range(0, 7));
            rs1        = 5'($urandom_range(0, 7));
            rs2        = 5'($urandom_range(0, 31));
            cyc();
        end
        drive_idle();
        rst_n = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
